// File: rtl/fifo_pixel_reader.sv
// Read-side consumer for the pixel FIFO: pops one first-word-fall-through word per
// load, re-emits it on a registered valid/ready stream tagged with raster markers.
module fifo_pixel_reader #(
  parameter int B    = 8,
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int CW   = 10,
  parameter int RW   = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic [B-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_sof,
  output logic         m_eol,
  output logic         m_eof,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [B-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           sof_q, sof_d;
  logic           eol_q, eol_d;
  logic           eof_q, eof_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic load;
  logic accept;
  logic at_sof;
  logic at_eol;
  logic at_eof;

  // The last word of a frame moves the FSM to DRAIN, so "last word loaded" is
  // simply "not in RUN" and needs no flag of its own.
  assign at_sof  = (col_q == '0) && (row_q == '0);
  assign at_eol  = (col_q == COL_LAST);
  assign at_eof  = at_eol && (row_q == ROW_LAST);
  assign accept  = valid_q && m_ready;
  assign load    = (state_q == RUN) && !fifo_empty && (!valid_q || m_ready);
  assign fifo_rd = load;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Output register: a load refills it (also on an accept edge), an accept alone empties it.
    if (load) begin
      data_d  = fifo_r_data;
      valid_d = 1'b1;
      sof_d   = at_sof;
      eol_d   = at_eol;
      eof_d   = at_eof;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (load) begin
          if (at_eol) begin
            col_d = '0;
            row_d = at_eof ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (at_eof) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the pixel register is reset too so
  // outputs read as zero during reset rather than stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign m_sof      = sof_q;
  assign m_eol      = eol_q;
  assign m_eof      = eof_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
